ring_input_buffer: RTL and testbench

//  Ingress packet store for one ring-router port. Writes each accepted packet into the

---
 rtl/ring_input_buffer_pkg.sv | 11 +
 rtl/ring_input_buffer_find_empty.sv | 16 +
 rtl/ring_input_buffer.sv | 59 +++++
 tb/tb_ring_input_buffer.sv | 111 +++++++++++
 4 files changed

// File: rtl/ring_input_buffer_pkg.sv
// ring_pkg: shared sizes and types for the ring-router input buffer
package ring_pkg;
   localparam int BUFFER_SIZE = 4;
   localparam int PACKET_SIZE = 49;
   localparam int PTR_LEN = 2;
   localparam int VALID_BIT = PACKET_SIZE - 1;
   typedef logic [PACKET_SIZE-1:0] packet_t;
   typedef logic [PTR_LEN-1:0] slot_ptr_t;
   typedef logic [PTR_LEN:0] count_t;
   localparam count_t OCC_MAX = count_t'(BUFFER_SIZE);
endpackage

// File: rtl/ring_input_buffer_find_empty.sv
// find_empty_buffer: lowest-index free slot finder, slot 0 has highest priority
module find_empty_buffer
   import ring_pkg::*;
(
   input  packet_t   buffer [BUFFER_SIZE],
   output slot_ptr_t empty_pos,
   output logic      empty_pos_found
);
   always_comb begin
      empty_pos_found = !(buffer[0][VALID_BIT] && buffer[1][VALID_BIT] &&
                          buffer[2][VALID_BIT] && buffer[3][VALID_BIT]);
      empty_pos = !buffer[0][VALID_BIT] ? 2'd0 :
                  !buffer[1][VALID_BIT] ? 2'd1 :
                  !buffer[2][VALID_BIT] ? 2'd2 : 2'd3;
   end
endmodule

// File: rtl/ring_input_buffer.sv
// ring_input_buffer: ingress packet store, lowest free slot write, arrival-order output
module ring_input_buffer
   import ring_pkg::*;
(
   input  logic    clk,
   input  logic    rst,
   input  logic    in_valid,
   input  packet_t in_packet,
   output logic    in_ready,
   output logic    out_valid,
   output packet_t out_packet,
   input  logic    out_ready,
   output count_t  occupancy
);
   packet_t   buffer [BUFFER_SIZE];
   slot_ptr_t queue  [BUFFER_SIZE];
   slot_ptr_t head, tail, empty_pos;
   logic      empty_pos_found, push, pop;
   find_empty_buffer u_find (
      .buffer          (buffer),
      .empty_pos       (empty_pos),
      .empty_pos_found (empty_pos_found)
   );
   always_comb begin
      in_ready   = empty_pos_found;
      out_valid  = occupancy != '0;
      out_packet = out_valid ? buffer[queue[head]] : '0;
      push       = in_valid && in_ready && in_packet[VALID_BIT];
      pop        = out_valid && out_ready;
   end
   // push targets a slot free before the edge, so it never collides with the popped slot
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < BUFFER_SIZE; i++) begin
            buffer[i] <= '0;
            queue[i]  <= '0;
         end
         head      <= '0;
         tail      <= '0;
         occupancy <= '0;
      end else begin
         if (push) begin
            buffer[empty_pos] <= in_packet;
            queue[tail]       <= empty_pos;
            tail              <= tail + 1'b1;
         end
         if (pop) begin
            buffer[queue[head]] <= '0;
            head                <= head + 1'b1;
         end
         occupancy <= (push && !pop) ? occupancy + 1'b1 :
                      (pop && !push) ? occupancy - 1'b1 : occupancy;
      end
   end
   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      occupancy <= OCC_MAX && !(push && !pop && occupancy == OCC_MAX));
   a_no_underflow: assert property (@(posedge clk) disable iff (rst)
      !(pop && !push && occupancy == '0));
endmodule

// File: tb/tb_ring_input_buffer.sv
// tb_ring_input_buffer: scoreboard bench, directed stimulus with arrival-order checking
module tb_ring_input_buffer;
   import ring_pkg::*;
   logic    clk = 0, rst = 1, in_valid = 0, out_ready = 0;
   packet_t in_packet = '0;
   logic    in_ready, out_valid;
   packet_t out_packet;
   count_t  occupancy;
   int      vectors = 0, miscompares = 0, m_occ = 0;
   packet_t sb [$];
   logic    hold = 0;
   packet_t last = '0;
   ring_input_buffer dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_packet  (in_packet),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_packet (out_packet),
      .out_ready  (out_ready),
      .occupancy  (occupancy)
   );
   always #5 clk = ~clk;
   function automatic packet_t mk(input int n);
      return {1'b1, 48'(n)};
   endfunction
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask
   // monitor: compares every handshake against the scoreboard, and checks hold stability
   always @(negedge clk) begin
      if (hold && !rst) chk("hold_stable", out_packet, last);
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) chk("unexpected_pop", out_packet, 64'hdead);
         else chk("out_packet", out_packet, sb.pop_front());
      end
      hold = !rst && out_valid && !out_ready;
      last = out_packet;
   end
   task automatic cyc(input logic iv, input packet_t pk, input logic ord);
      logic acc;
      in_valid = iv; in_packet = pk; out_ready = ord;
      #1;
      chk("in_ready", in_ready, m_occ < 4);
      acc = iv && m_occ < 4 && pk[VALID_BIT];
      if (acc) sb.push_back(pk);
      @(posedge clk); #1;
      m_occ += int'(acc) - int'(ord && m_occ > 0);
      chk("occupancy", occupancy, m_occ);
      chk("out_valid", out_valid, m_occ != 0);
   endtask
   task automatic drain();
      for (int i = 0; i < 6; i++) cyc(0, '0, 1);
   endtask
   initial begin
      @(posedge clk); #1;
      rst = 0;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_packet", out_packet, 0);
      chk("rst_occupancy", occupancy, 0);
      // fill all four slots with the consumer stalled
      for (int i = 0; i < 4; i++) cyc(1, mk(16'hA0 + i), 0);
      chk("full_in_ready", in_ready, 0);
      chk("full_head", out_packet, mk(16'hA0));
      for (int i = 0; i < 4; i++) chk("slot_fill", dut.buffer[i], mk(16'hA0 + i));
      // full: pop and offer in the same cycle, offer refused until next cycle
      cyc(1, mk(16'hE0), 1);
      cyc(1, mk(16'hE0), 0);
      chk("reuse_slot0", dut.buffer[0], mk(16'hE0));
      drain();
      // slot reuse keeps arrival order
      for (int i = 0; i < 3; i++) cyc(1, mk(16'hB0 + i), 0);
      cyc(0, '0, 1);
      cyc(1, mk(16'hB3), 0);
      chk("d_in_slot0", dut.buffer[0], mk(16'hB3));
      chk("head_after_reuse", out_packet, mk(16'hB1));
      drain();
      // streaming with both sides always active
      for (int i = 0; i < 100; i++) cyc(1, mk(1000 + i), 1);
      drain();
      // packet without its valid bit is dropped
      cyc(1, {1'b0, 48'h123456}, 0);
      chk("invalid_slot0", dut.buffer[0], 0);
      cyc(1, mk(16'hC0), 0);
      cyc(1, {1'b0, 48'h777}, 0);
      chk("invalid_slot1", dut.buffer[1], 0);
      drain();
      // reset wins over push and pop in the same cycle
      for (int i = 0; i < 3; i++) cyc(1, mk(16'hD0 + i), 0);
      rst = 1; in_valid = 1; in_packet = mk(16'hDF); out_ready = 1;
      @(posedge clk); #1;
      rst = 0; in_valid = 0; out_ready = 0;
      sb.delete(); m_occ = 0;
      chk("mid_rst_occupancy", occupancy, 0);
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_out_packet", out_packet, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      for (int i = 0; i < 4; i++) chk("mid_rst_slot", dut.buffer[i], 0);
      cyc(1, mk(16'hF0), 0);
      cyc(0, '0, 1);
      chk("sb_empty", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
